ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
- Parametrised return address stack for the frontend branch predictor, built as a circular buffer with a top-of-stack (TOS) pointer and an occupancy counter.
- Adds per-branch checkpoint save/restore for misprediction repair. A restore puts back the TOS pointer, the count and the top entry's content.
- Adds overflow and underflow reporting.
- Sits between the frontend's call/return decode and the next-PC mux; predicted return targets are taken from top_ra_o.

Parameters:
- VLEN, 64, return address width in bits.
- DEPTH, 8, number of stack entries; must be >= 2; need not be a power of two.
- NR_CKPT, 4, number of checkpoint slots; must be >= 1.
- CKPT_IDW, max(1,$clog2(NR_CKPT)), checkpoint id width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  clear stack and all checkpoints
- push_i  in  1  push data_i (call)
- pop_i  in  1  pop top (return)
- data_i  in  VLEN  return address to push
- ckpt_save_i  in  1  save checkpoint
- ckpt_save_id_i  in  CKPT_IDW  slot to save into
- ckpt_restore_i  in  1  restore checkpoint
- ckpt_restore_id_i  in  CKPT_IDW  slot to restore from
- top_ra_o  out  VLEN  top entry; 0 when empty
- top_valid_o  out  1  count_o != 0
- count_o  out  $clog2(DEPTH+1)  occupancy
- overflow_o  out  1  one-cycle pulse: push at full overwrote the oldest entry
- underflow_o  out  1  one-cycle pulse: pop on empty

Behaviour:
- State: mem[DEPTH] x VLEN, ptr (TOS index), count, ckpt[NR_CKPT] = {ptr, count, ra}, and registered overflow/underflow flags.
- Reset (rst_i high, async): mem, ckpt, ptr, count and both flags are 0. All outputs are 0 while rst_i is high and in the first cycle after release.
- Outputs are driven from registered state only; there is no same-cycle bypass. Push/pop effects appear one cycle after the edge.
- Wrap arithmetic: inc(p) = (p==DEPTH-1) ? 0 : p+1; dec(p) = (p==0) ? DEPTH-1 : p-1.
- Priority each cycle: flush_i > ckpt_restore_i > push/pop. ckpt_save is evaluated last.
- flush_i: ptr=0, count=0, all mem and ckpt entries are zeroed, flags are 0. Restore, push and pop are ignored in that cycle.
- ckpt_restore_i (no flush): ptr=ckpt[id].ptr, count=ckpt[id].count, mem[ckpt[id].ptr]=ckpt[id].ra. Push and pop are ignored in that cycle. No flag pulse.
- push only:
  - ptr=inc(ptr), mem[inc(ptr)]=data_i.
  - If count<DEPTH, count+1.
  - Else count stays DEPTH and overflow_o pulses next cycle.
- pop only:
  - If count>0: ptr=dec(ptr), count-1. The vacated entry is not cleared.
  - If count==0: state is unchanged and underflow_o pulses next cycle.
- push and pop together:
  - If count>0: mem[ptr]=data_i; ptr and count are unchanged.
  - If count==0: acts as push only.
  - No flag pulse in either case.
- ckpt_save_i: ckpt[save_id] = {ptr_next, count_next, mem_next[ptr_next]}, i.e. the state resulting from this cycle's operations. This includes a same-cycle restore or flush.
- Save and restore of the same id in one cycle: the slot receives the restored state, which leaves it unchanged.
- Restoring a never-saved or flushed slot yields the empty state (count 0).
- Flag pulses last exactly one cycle. Back-to-back overflowing pushes produce a pulse on every cycle.

Test Plan:
- Reset: assert rst_i mid-stream with count=3 -> outputs 0 without waiting for a clock edge; after release, top_valid_o=0 and count_o=0.
- Fill/wrap (DEPTH=4, VLEN=32): push 0x100, 0x104, 0x108, 0x10C, 0x110 -> count_o=4 after the 4th push; overflow_o=1 for one cycle after the 5th; top_ra_o=0x110. Four pops -> top 0x10C, 0x108, 0x104, then empty (top_ra_o=0). A 5th pop -> underflow_o=1 for one cycle, count_o stays 0.
- Replace: with top 0x200 and count 2, push+pop with data_i=0x300 -> top 0x300, count 2, no flags. On an empty stack, push+pop with data_i=0x300 -> count 1, top 0x300.
- Checkpoint repair: push 0x100, 0x200; save id 1; pop; push 0x900 (overwrites the 0x200 slot); restore id 1 -> top 0x200, count 2. Next pop -> top 0x100.
- Priority: restore id 1 together with push 0xAAA -> push ignored, restored state shown. flush together with restore -> count 0, and a subsequent restore id 1 -> empty.
- Save-with-push: on an empty stack, push 0x500 while saving id 0; pop; restore id 0 -> top 0x500, count 1.

Source files
------------

// File: rtl/ras_ckpt.sv
// Return address stack (circular buffer) with per-branch checkpoints for
// misprediction repair, plus overflow/underflow pulse reporting.
module ras_ckpt #(
    parameter int VLEN     = 64,
    parameter int DEPTH    = 8,
    parameter int NR_CKPT  = 4,
    parameter int CKPT_IDW = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [VLEN-1:0]            data_i,
    input  logic                       ckpt_save_i,
    input  logic [CKPT_IDW-1:0]        ckpt_save_id_i,
    input  logic                       ckpt_restore_i,
    input  logic [CKPT_IDW-1:0]        ckpt_restore_id_i,
    output logic [VLEN-1:0]            top_ra_o,
    output logic                       top_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PTRW = $clog2(DEPTH);

    logic [VLEN-1:0] mem_q    [DEPTH];
    logic [PTRW-1:0] ptr_q,   ptr_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic [VLEN-1:0] top_q,   top_d;
    logic            ovf_q,   ovf_d;
    logic            unf_q,   unf_d;
    logic [PTRW-1:0] ck_ptr_q [NR_CKPT];
    logic [CNTW-1:0] ck_cnt_q [NR_CKPT];
    logic [VLEN-1:0] ck_ra_q  [NR_CKPT];

    logic            we_s;
    logic [PTRW-1:0] waddr_s;
    logic [VLEN-1:0] wdata_s;
    logic [VLEN-1:0] ra_d;
    logic [PTRW-1:0] ptr_inc_s, ptr_dec_s;
    logic [PTRW-1:0] rs_ptr_s;
    logic [CNTW-1:0] rs_cnt_s;
    logic [VLEN-1:0] rs_ra_s;
    logic            save_ok_s;

    assign ptr_inc_s = (ptr_q == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}} : ptr_q + PTRW'(1);
    assign ptr_dec_s = (ptr_q == {PTRW{1'b0}}) ? PTRW'(DEPTH - 1) : ptr_q - PTRW'(1);
    assign save_ok_s = ckpt_save_i && (int'(ckpt_save_id_i) < NR_CKPT);

    // Out-of-range restore ids read back as the empty state.
    always_comb begin
        rs_ptr_s = {PTRW{1'b0}};
        rs_cnt_s = {CNTW{1'b0}};
        rs_ra_s  = {VLEN{1'b0}};
        if (int'(ckpt_restore_id_i) < NR_CKPT) begin
            rs_ptr_s = ck_ptr_q[ckpt_restore_id_i];
            rs_cnt_s = ck_cnt_q[ckpt_restore_id_i];
            rs_ra_s  = ck_ra_q[ckpt_restore_id_i];
        end else begin
            rs_ptr_s = {PTRW{1'b0}};
        end
    end

    // Next-state selection: flush > restore > push/pop.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        waddr_s = ptr_q;
        wdata_s = data_i;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (flush_i) begin
            ptr_d = {PTRW{1'b0}};
            cnt_d = {CNTW{1'b0}};
        end else if (ckpt_restore_i) begin
            ptr_d   = rs_ptr_s;
            cnt_d   = rs_cnt_s;
            we_s    = 1'b1;
            waddr_s = rs_ptr_s;
            wdata_s = rs_ra_s;
        end else if (push_i && pop_i && (cnt_q != {CNTW{1'b0}})) begin
            we_s = 1'b1;
        end else if (push_i) begin
            ptr_d   = ptr_inc_s;
            we_s    = 1'b1;
            waddr_s = ptr_inc_s;
            if (cnt_q < CNTW'(DEPTH)) begin
                cnt_d = cnt_q + CNTW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop_i) begin
            if (cnt_q != {CNTW{1'b0}}) begin
                ptr_d = ptr_dec_s;
                cnt_d = cnt_q - CNTW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Top entry as it will read after this cycle's write lands.
    always_comb begin
        ra_d = mem_q[ptr_d];
        if (flush_i) begin
            ra_d = {VLEN{1'b0}};
        end else if (we_s && (waddr_s == ptr_d)) begin
            ra_d = wdata_s;
        end else begin
            ra_d = mem_q[ptr_d];
        end
        top_d = (cnt_d != {CNTW{1'b0}}) ? ra_d : {VLEN{1'b0}};
    end

    // Stack storage, pointer, occupancy and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {VLEN{1'b0}};
            ptr_q <= {PTRW{1'b0}};
            cnt_q <= {CNTW{1'b0}};
            top_q <= {VLEN{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= {VLEN{1'b0}};
            end else if (we_s) begin
                mem_q[waddr_s] <= wdata_s;
            end
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Checkpoint slots; a save captures post-update state, after any flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_CKPT; i++) begin
                ck_ptr_q[i] <= {PTRW{1'b0}};
                ck_cnt_q[i] <= {CNTW{1'b0}};
                ck_ra_q[i]  <= {VLEN{1'b0}};
            end
        end else begin
            if (flush_i) begin
                for (int i = 0; i < NR_CKPT; i++) begin
                    ck_ptr_q[i] <= {PTRW{1'b0}};
                    ck_cnt_q[i] <= {CNTW{1'b0}};
                    ck_ra_q[i]  <= {VLEN{1'b0}};
                end
            end
            if (save_ok_s) begin
                ck_ptr_q[ckpt_save_id_i] <= ptr_d;
                ck_cnt_q[ckpt_save_id_i] <= cnt_d;
                ck_ra_q[ckpt_save_id_i]  <= ra_d;
            end
        end
    end

    assign top_ra_o    = top_q;
    assign top_valid_o = (cnt_q != {CNTW{1'b0}});
    assign count_o     = cnt_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt (DEPTH=4, VLEN=32): directed steps queue their
// expected post-edge outputs; a negedge monitor pops and compares.
module tb_ras_ckpt;
    localparam int VLEN = 32;
    localparam int DEPTH = 4;
    localparam int NR_CKPT = 4;
    localparam int IDW = 2;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0, push = 1'b0, pop = 1'b0;
    logic [VLEN-1:0] data = 32'h0;
    logic            sv = 1'b0, rs = 1'b0;
    logic [IDW-1:0]  sv_id = 2'd0, rs_id = 2'd0;
    logic [VLEN-1:0] top_ra;
    logic            top_valid, ovf, unf;
    logic [CNTW-1:0] count;

    typedef struct {
        int              cyc;
        int              id;
        logic [VLEN-1:0] top;
        logic [CNTW-1:0] cnt;
        logic            ovf;
        logic            unf;
    } exp_t;

    exp_t sb[$];
    int   cyc_r = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   step_id = 0;

    ras_ckpt #(.VLEN(VLEN), .DEPTH(DEPTH), .NR_CKPT(NR_CKPT)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
        .data_i(data), .ckpt_save_i(sv), .ckpt_save_id_i(sv_id),
        .ckpt_restore_i(rs), .ckpt_restore_id_i(rs_id),
        .top_ra_o(top_ra), .top_valid_o(top_valid), .count_o(count),
        .overflow_o(ovf), .underflow_o(unf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_r <= cyc_r + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [VLEN+CNTW+2:0] got, want;
        while (sb.size() > 0 && sb[0].cyc <= cyc_r) begin
            e = sb.pop_front();
            got  = {top_ra, top_valid, count, ovf, unf};
            want = {e.top, (e.cnt != 3'd0), e.cnt, e.ovf, e.unf};
            n_chk++;
            if (e.cyc != cyc_r) begin
                $display("FAIL step%0d stale expectation: due cycle %0d, now %0d", e.id, e.cyc, cyc_r);
            end else if (got !== want) begin
                $display("FAIL step%0d got top=%h v=%b cnt=%0d ovf=%b unf=%b, want top=%h v=%b cnt=%0d ovf=%b unf=%b",
                         e.id, top_ra, top_valid, count, ovf, unf,
                         e.top, (e.cnt != 3'd0), e.cnt, e.ovf, e.unf);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic step(input logic f, input logic pu, input logic po, input logic [VLEN-1:0] d,
                        input logic s, input logic [IDW-1:0] sid,
                        input logic r, input logic [IDW-1:0] rid,
                        input logic [VLEN-1:0] e_top, input logic [CNTW-1:0] e_cnt,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        flush = f; push = pu; pop = po; data = d;
        sv = s; sv_id = sid; rs = r; rs_id = rid;
        step_id++;
        e.cyc = cyc_r + 1; e.id = step_id;
        e.top = e_top; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
        sb.push_back(e);
        @(posedge clk); #2;
    endtask

    task automatic idle(input logic [VLEN-1:0] e_top, input logic [CNTW-1:0] e_cnt);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, e_top, e_cnt, 1'b0, 1'b0);
    endtask

    task automatic do_push(input logic [VLEN-1:0] d, input logic [VLEN-1:0] e_top,
                           input logic [CNTW-1:0] e_cnt, input logic e_ovf);
        step(1'b0, 1'b1, 1'b0, d, 1'b0, 2'd0, 1'b0, 2'd0, e_top, e_cnt, e_ovf, 1'b0);
    endtask

    task automatic do_pop(input logic [VLEN-1:0] e_top, input logic [CNTW-1:0] e_cnt, input logic e_unf);
        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, e_top, e_cnt, 1'b0, e_unf);
    endtask

    task automatic do_flush();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(32'h0, 3'd0);

        // Asynchronous reset mid-stream
        do_push(32'h11, 32'h11, 3'd1, 1'b0);
        do_push(32'h22, 32'h22, 3'd2, 1'b0);
        do_push(32'h33, 32'h33, 3'd3, 1'b0);
        push = 1'b0; data = 32'h0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({top_ra, top_valid, count, ovf, unf} !== {VLEN+CNTW+3{1'b0}})
            $display("FAIL async_reset got top=%h v=%b cnt=%0d ovf=%b unf=%b, want all 0",
                     top_ra, top_valid, count, ovf, unf);
        else
            n_pass++;
        @(posedge clk); #2;
        rst = 1'b0;
        idle(32'h0, 3'd0);

        // Fill, wrap with overflow, drain, underflow
        do_push(32'h100, 32'h100, 3'd1, 1'b0);
        do_push(32'h104, 32'h104, 3'd2, 1'b0);
        do_push(32'h108, 32'h108, 3'd3, 1'b0);
        do_push(32'h10C, 32'h10C, 3'd4, 1'b0);
        do_push(32'h110, 32'h110, 3'd4, 1'b1);
        idle(32'h110, 3'd4);
        do_pop(32'h10C, 3'd3, 1'b0);
        do_pop(32'h108, 3'd2, 1'b0);
        do_pop(32'h104, 3'd1, 1'b0);
        do_pop(32'h0, 3'd0, 1'b0);
        do_pop(32'h0, 3'd0, 1'b1);
        idle(32'h0, 3'd0);

        // Replace via push+pop, non-empty and empty
        do_flush();
        do_push(32'h100, 32'h100, 3'd1, 1'b0);
        do_push(32'h200, 32'h200, 3'd2, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 2'd0, 1'b0, 2'd0, 32'h300, 3'd2, 1'b0, 1'b0);
        do_pop(32'h100, 3'd1, 1'b0);
        do_flush();
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 2'd0, 1'b0, 2'd0, 32'h300, 3'd1, 1'b0, 1'b0);

        // Checkpoint repair
        do_flush();
        do_push(32'h100, 32'h100, 3'd1, 1'b0);
        do_push(32'h200, 32'h200, 3'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 2'd0, 32'h200, 3'd2, 1'b0, 1'b0);
        do_pop(32'h100, 3'd1, 1'b0);
        do_push(32'h900, 32'h900, 3'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h200, 3'd2, 1'b0, 1'b0);
        do_pop(32'h100, 3'd1, 1'b0);

        // Priority: restore beats push; flush beats restore and clears slots
        step(1'b0, 1'b1, 1'b0, 32'hAAA, 1'b0, 2'd0, 1'b1, 2'd1, 32'h200, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h0, 3'd0, 1'b0, 1'b0);

        // Save captures the same-cycle push
        step(1'b0, 1'b1, 1'b0, 32'h500, 1'b1, 2'd0, 1'b0, 2'd0, 32'h500, 3'd1, 1'b0, 1'b0);
        do_pop(32'h0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 2'd0, 32'h500, 3'd1, 1'b0, 1'b0);

        // Back-to-back overflowing pushes pulse every cycle
        do_flush();
        do_push(32'h1, 32'h1, 3'd1, 1'b0);
        do_push(32'h2, 32'h2, 3'd2, 1'b0);
        do_push(32'h3, 32'h3, 3'd3, 1'b0);
        do_push(32'h4, 32'h4, 3'd4, 1'b0);
        do_push(32'h5, 32'h5, 3'd4, 1'b1);
        do_push(32'h6, 32'h6, 3'd4, 1'b1);
        idle(32'h6, 3'd4);
        do_pop(32'h5, 3'd3, 1'b0);

        begin : drain
            int waited = 0;
            while (sb.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if (sb.size() > 0) begin
                n_chk++;
                $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
            end
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
